// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep capture block.
package tt_sweep_pkg;

   localparam int N_IN       = 4;
   localparam int TT_W       = 16;
   localparam int SETTLE_MAX = 15;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == ST_SETTLE) || (s == ST_SAMPLE);
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle counter: clears on request, counts while enabled and
// flags the last wait cycle of a row.
module tt_settle_timer
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic terminal_o
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // next count: clear wins over increment
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal_o = (count_q == TERM);

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 16 input combinations into a 4-input gate, samples its output
// after a settle delay per row, and publishes the captured truth table.
module tt_sweep_capture
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [TT_W-1:0] expected,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] tt,
   output logic [TT_W-1:0] mismatch_mask,
   output logic            match
);

   state_e          state_q, state_d;
   logic [N_IN-1:0] row_q, row_d;
   logic [TT_W-1:0] exp_q, exp_d;
   logic [TT_W-1:0] shadow_q, shadow_d;
   logic [TT_W-1:0] tt_q, tt_d;
   logic [TT_W-1:0] mask_q, mask_d;
   logic            match_q, match_d;
   logic [N_IN-1:0] dut_in_q, dut_in_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            timer_clr_s;
   logic            timer_en_s;
   logic            timer_term_s;

   assign timer_en_s  = (state_q == ST_SETTLE);
   assign timer_clr_s = (state_q != ST_SETTLE) || timer_term_s;

   tt_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (timer_clr_s),
      .en_i       (timer_en_s),
      .terminal_o (timer_term_s)
   );

   // next state, capture and result publication
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      exp_d    = exp_q;
      shadow_d = shadow_q;
      tt_d     = tt_q;
      mask_d   = mask_q;
      match_d  = match_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d  = ST_SETTLE;
               row_d    = {N_IN{1'b0}};
               exp_d    = expected;
               shadow_d = {TT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_term_s) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            // abort drops the pending capture as well as the sweep
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               shadow_d[row_q] = dut_out;
               if (row_q == 4'd15) begin
                  state_d = ST_DONE;
                  tt_d    = shadow_d;
                  mask_d  = shadow_d ^ exp_q;
                  match_d = ((shadow_d ^ exp_q) == {TT_W{1'b0}});
               end else begin
                  state_d = ST_SETTLE;
                  row_d   = row_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d   = is_busy(state_d);
      done_d   = (state_d == ST_DONE);
      dut_in_d = busy_d ? row_d : {N_IN{1'b0}};
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         row_q    <= {N_IN{1'b0}};
         exp_q    <= {TT_W{1'b0}};
         shadow_q <= {TT_W{1'b0}};
         tt_q     <= {TT_W{1'b0}};
         mask_q   <= {TT_W{1'b0}};
         match_q  <= 1'b0;
         dut_in_q <= {N_IN{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         exp_q    <= exp_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         mask_q   <= mask_d;
         match_q  <= match_d;
         dut_in_q <= dut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign dut_in        = dut_in_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign tt            = tt_q;
   assign mismatch_mask = mask_q;
   assign match         = match_q;

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles per row before sampling; legal range 1..15.
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request a 16-row truth-table sweep; honoured only in IDLE.
REQ-005 Port: abort  in  1  cancel sweep in progress.
REQ-006 Port: expected  in  16  expected truth table, latched on start acceptance.
REQ-007 Port: dut_in  out  4  drives the 4-input gate under test; bit0 to input _0 ... bit3 to input _3.
REQ-008 Port: dut_out  in  1  gate under test output (_4), combinational from dut_in.
REQ-009 Port: busy  out  1  high in SETTLE and SAMPLE states.
REQ-010 Port: done  out  1  one-cycle pulse on sweep completion.
REQ-011 Port: tt  out  16  captured truth table; bit i = dut_out sampled with dut_in == i.
REQ-012 Port: mismatch_mask  out  16  tt XOR latched expected.
REQ-013 Port: match  out  1  high when mismatch_mask == 0.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE; registered, one state per cycle.
REQ-015 IDLE: dut_in = 0; start high at an edge -> SETTLE, row = 0, settle count = 0, expected latched, shadow table cleared.
REQ-016 SETTLE: dut_in = row; count increments each cycle; when count == SETTLE-1 -> SAMPLE.
REQ-017 SAMPLE: dut_in = row; at the edge, shadow[row] <= dut_out; row < 15 -> row+1, count = 0, SETTLE; row == 15 -> DONE.
REQ-018 Each row occupies exactly SETTLE+1 cycles; dut_in changes only at row boundaries.
REQ-019 DONE: entered 16*(SETTLE+1) edges after start acceptance; on entry, tt <= shadow, mismatch_mask and match updated; done high for that one cycle; next state IDLE.
REQ-020 tt, mismatch_mask, match hold their values from the last completed sweep until the next DONE; never show partial results.
REQ-021 start while busy or in DONE: ignored, no queuing.
REQ-022 start held high continuously: back-to-back sweeps, exactly one IDLE cycle between DONE and next SETTLE.
REQ-023 abort high in SETTLE or SAMPLE: next state IDLE, no done pulse, no result update, dut_in = 0 next cycle; abort has priority over a same-cycle SAMPLE capture.
REQ-024 abort in IDLE or DONE: no effect; abort and start together in IDLE: start ignored.
REQ-025 Row counter 4 bits, never wraps; termination at row 15 only.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, row 0, count 0, dut_in 0, busy 0, done 0, tt 0, mismatch_mask 0, match 0, latched expected 0.
REQ-027 Reset mid-sweep discards the sweep; no done pulse follows reset release.
REQ-028 First start accepted at the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package tt_sweep_pkg holds: state enum, N_IN = 4, TT_W = 16, SETTLE_MAX = 15.
REQ-030 One sub-module: tt_settle_timer (count register, clear, terminal flag at SETTLE-1); all else in top.
REQ-031 All outputs driven directly from registers; no combinational path from dut_out to any output.

Verification
REQ-032 SETTLE=2, behavioural 0x8F63 gate attached, expected=16'h8F63, start pulse -> done at edge 48 after start, tt=16'h8F63, mask=0, match=1.
REQ-033 dut_out tied 0, expected=16'h8F63 -> tt=16'h0000, mismatch_mask=16'h8F63, match=0.
REQ-034 Monitor dut_in during sweep, SETTLE=3 -> sequence 0..15, each value held exactly 4 cycles, sample on 4th; returns to 0 after DONE.
REQ-035 abort asserted while row==7 -> busy low next cycle, no done, tt/match unchanged from previous sweep, dut_in=0.
REQ-036 rst_n pulsed low at row 10 -> all outputs 0 immediately (before next edge), no done after release; start then yields a normal full sweep.
REQ-037 start held high 3 sweeps -> three done pulses spaced 16*(SETTLE+1)+2 cycles apart; start pulses while busy produce no extra sweep.
